seg7_scan: RTL

Multiplexed four-digit seven-segment display driver for the timer. Consumes the BCD time digits produced by `counter` (`min_hi`, `min_lo`, `sec_hi`, `sec_lo`) and scans them onto a common-anode display. Each digit is shown for a fixed number of clocks with dead time between digits. Digits are snapshotted once per frame so that a counter update never tears a displayed value.

---
 rtl/seg7_scan_pkg.sv | 44 ++++
 rtl/seg7_scan_bcd_to_seg.sv | 29 ++
 rtl/seg7_scan.sv | 113 +++++++++++
 3 files changed

// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the seven-segment display blocks.
// Segment patterns are active-low with bit 0 = a ... bit 6 = g.
// Digit enables are active-low; DIG_OFF turns every digit off.
package seg7_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [3:0] DIG_OFF   = 4'b1111;

    // Digit slot order; the value is also the bit position in dig.
    typedef enum logic [1:0] {
        SLOT_SEC_LO = 2'd0,
        SLOT_SEC_HI = 2'd1,
        SLOT_MIN_LO = 2'd2,
        SLOT_MIN_HI = 2'd3
    } slot_e;

    // Frame snapshot of everything the display shows.
    typedef struct packed {
        logic [3:0] min_hi;
        logic [3:0] min_lo;
        logic [2:0] sec_hi;
        logic [3:0] sec_lo;
        logic       colon;
        logic       blank_lz;
    } snap_t;

    // Active-low one-hot enable for a slot.
    function automatic logic [3:0] dig_enable(slot_e slot);
        return ~(4'b0001 << slot);
    endfunction

endpackage

// File: rtl/seg7_scan_bcd_to_seg.sv
// bcd_to_seg: combinational 4-bit value to active-low seven-segment pattern.
// Ports:
//   value - digit value 0..15
//   seg   - active-low segments (bit 0 = a ... bit 6 = g); 10..15 give a dash
module bcd_to_seg
    import seg7_scan_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (value)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed common-anode display driver for the timer.
// Each digit owns a slot of SCAN_DIV clocks whose first DEAD clocks are dark.
// The digit values are captured once per frame so a counter update never
// tears the displayed time.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   min_hi, min_lo      - minutes tens/units (BCD)
//   sec_hi, sec_lo      - seconds tens (0..5) / units (BCD)
//   blank_lz            - suppress a leading zero in min_hi
//   colon               - light the dp of the min_lo digit
//   seg, dp, dig        - registered active-low segments, dp, digit enables
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] min_hi,
    input  logic [3:0] min_lo,
    input  logic [2:0] sec_hi,
    input  logic [3:0] sec_lo,
    input  logic       blank_lz,
    input  logic       colon,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] dig
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD);

    logic [CNT_W-1:0] cnt;
    slot_e            idx;
    snap_t            snap;

    logic [3:0] digit_val;
    logic [6:0] digit_seg;
    logic [6:0] seg_nxt;
    logic       dp_nxt;
    logic [3:0] dig_nxt;

    always_comb begin
        digit_val = 4'd0;
        case (idx)
            SLOT_SEC_LO: digit_val = snap.sec_lo;
            SLOT_SEC_HI: digit_val = {1'b0, snap.sec_hi};
            SLOT_MIN_LO: digit_val = snap.min_lo;
            SLOT_MIN_HI: digit_val = snap.min_hi;
            default:     digit_val = 4'd0;
        endcase
    end

    bcd_to_seg u_dec (
        .value (digit_val),
        .seg   (digit_seg)
    );

    // Outputs for the next edge are derived from the current cnt/idx/snap,
    // giving one clock of latency relative to the slot counters.
    always_comb begin
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        dig_nxt = DIG_OFF;
        if (cnt >= DEAD_END) begin
            dig_nxt = dig_enable(idx);
            seg_nxt = digit_seg;
            // The min_hi digit stays enabled when blanked; only its segments go dark.
            if (idx == SLOT_MIN_HI && snap.blank_lz && snap.min_hi == 4'd0) begin
                seg_nxt = SEG_BLANK;
            end
            if (idx == SLOT_MIN_LO && snap.colon) begin
                dp_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            idx  <= SLOT_SEC_LO;
            snap <= '0;
            seg  <= SEG_BLANK;
            dp   <= 1'b1;
            dig  <= DIG_OFF;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= slot_e'(idx + 2'd1);
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Capture at the start of each frame; that edge is always dark,
            // so the new values are in place before any digit lights.
            if (cnt == '0 && idx == SLOT_SEC_LO) begin
                snap <= '{min_hi:   min_hi,
                          min_lo:   min_lo,
                          sec_hi:   sec_hi,
                          sec_lo:   sec_lo,
                          colon:    colon,
                          blank_lz: blank_lz};
            end

            seg <= seg_nxt;
            dp  <= dp_nxt;
            dig <= dig_nxt;
        end
    end

endmodule
